// File: rtl/vid_timing_gen_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : vid_timing_gen_if
// Brief    : Pixel-fetch and video-output bundle for vid_timing_gen.
// Revision : 1.0 - initial release
// ============================================================================
interface vid_timing_gen_if;
    logic        EN;
    logic        MODE;
    logic [14:0] PIX_RGB;
    logic        PIX_REQ;
    logic [10:0] PIX_X;
    logic [9:0]  PIX_Y;
    logic [4:0]  VID_R;
    logic [4:0]  VID_G;
    logic [4:0]  VID_B;
    logic        VID_HS;
    logic        VID_VS;
    logic        VID_DE;
    logic        FRAME_START;
    logic        MODE_ACT;

    // master: the timing generator; slave: the pixel source / encoder side
    modport master (
        input  EN, MODE, PIX_RGB,
        output PIX_REQ, PIX_X, PIX_Y, VID_R, VID_G, VID_B,
               VID_HS, VID_VS, VID_DE, FRAME_START, MODE_ACT
    );

    modport slave (
        output EN, MODE, PIX_RGB,
        input  PIX_REQ, PIX_X, PIX_Y, VID_R, VID_G, VID_B,
               VID_HS, VID_VS, VID_DE, FRAME_START, MODE_ACT
    );
endinterface
`default_nettype wire

// File: rtl/vid_timing_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : vid_timing_gen
// Brief    : Two-set video timing generator with pixel fetch and 2-stage
//            output pipeline (fetch request, then pixel/sync to encoder).
// Revision : 1.0 - initial release
// ============================================================================
module vid_timing_gen #(
    parameter int A_H_ACT  = 640,
    parameter int A_H_FP   = 16,
    parameter int A_H_SYNC = 96,
    parameter int A_H_BP   = 48,
    parameter int A_V_ACT  = 480,
    parameter int A_V_FP   = 10,
    parameter int A_V_SYNC = 2,
    parameter int A_V_BP   = 33,
    parameter int B_H_ACT  = 720,
    parameter int B_H_FP   = 12,
    parameter int B_H_SYNC = 64,
    parameter int B_H_BP   = 68,
    parameter int B_V_ACT  = 576,
    parameter int B_V_FP   = 5,
    parameter int B_V_SYNC = 5,
    parameter int B_V_BP   = 39
) (
    input  wire logic       VID_CLK,
    input  wire logic       VID_RST,
    vid_timing_gen_if.master bus
);

    typedef enum logic [1:0] {
        H_ACTIVE = 2'd0,
        H_FP     = 2'd1,
        H_SYNC   = 2'd2,
        H_BP     = 2'd3
    } h_state_t;

    typedef enum logic [1:0] {
        V_ACTIVE = 2'd0,
        V_FP     = 2'd1,
        V_SYNC   = 2'd2,
        V_BP     = 2'd3
    } v_state_t;

    localparam logic [10:0] c_a_h_act  = 11'(A_H_ACT);
    localparam logic [10:0] c_a_h_fp   = 11'(A_H_FP);
    localparam logic [10:0] c_a_h_sync = 11'(A_H_SYNC);
    localparam logic [10:0] c_a_h_bp   = 11'(A_H_BP);
    localparam logic [9:0]  c_a_v_act  = 10'(A_V_ACT);
    localparam logic [9:0]  c_a_v_fp   = 10'(A_V_FP);
    localparam logic [9:0]  c_a_v_sync = 10'(A_V_SYNC);
    localparam logic [9:0]  c_a_v_bp   = 10'(A_V_BP);
    localparam logic [10:0] c_b_h_act  = 11'(B_H_ACT);
    localparam logic [10:0] c_b_h_fp   = 11'(B_H_FP);
    localparam logic [10:0] c_b_h_sync = 11'(B_H_SYNC);
    localparam logic [10:0] c_b_h_bp   = 11'(B_H_BP);
    localparam logic [9:0]  c_b_v_act  = 10'(B_V_ACT);
    localparam logic [9:0]  c_b_v_fp   = 10'(B_V_FP);
    localparam logic [9:0]  c_b_v_sync = 10'(B_V_SYNC);
    localparam logic [9:0]  c_b_v_bp   = 10'(B_V_BP);

    h_state_t    r_h_state;
    h_state_t    w_h_state_nxt;
    v_state_t    r_v_state;
    v_state_t    w_v_state_nxt;
    logic [10:0] r_hcnt;
    logic [10:0] w_hcnt_nxt;
    logic [9:0]  r_vcnt;
    logic [9:0]  w_vcnt_nxt;

    logic        r_en_d;
    logic        r_mode_act;
    logic        w_en_rise;
    logic        w_mode_eff;

    logic [10:0] w_h_len;
    logic [9:0]  w_v_len;
    logic        w_h_last;
    logic        w_v_last;
    logic        w_line_end;
    logic        w_frame_end;

    logic        w_de0;
    logic        w_hs0;
    logic        w_vs0;
    logic        w_fs0;

    logic        r_pix_req;
    logic [10:0] r_pix_x;
    logic [9:0]  r_pix_y;
    logic        r_hs1;
    logic        r_vs1;
    logic        r_fs1;

    logic        r_vid_de;
    logic        r_vid_hs;
    logic        r_vid_vs;
    logic        r_frame_start;
    logic [4:0]  r_vid_r;
    logic [4:0]  r_vid_g;
    logic [4:0]  r_vid_b;

    // On the first enabled clock MODE is taken directly so the opening
    // phase already uses the requested set.
    assign w_en_rise  = bus.EN && !r_en_d;
    assign w_mode_eff = w_en_rise ? bus.MODE : r_mode_act;

    always_comb begin
        w_h_len = c_a_h_act;
        unique case (r_h_state)
            H_ACTIVE: w_h_len = w_mode_eff ? c_b_h_act  : c_a_h_act;
            H_FP:     w_h_len = w_mode_eff ? c_b_h_fp   : c_a_h_fp;
            H_SYNC:   w_h_len = w_mode_eff ? c_b_h_sync : c_a_h_sync;
            H_BP:     w_h_len = w_mode_eff ? c_b_h_bp   : c_a_h_bp;
            default:  w_h_len = c_a_h_act;
        endcase
    end

    always_comb begin
        w_v_len = c_a_v_act;
        unique case (r_v_state)
            V_ACTIVE: w_v_len = w_mode_eff ? c_b_v_act  : c_a_v_act;
            V_FP:     w_v_len = w_mode_eff ? c_b_v_fp   : c_a_v_fp;
            V_SYNC:   w_v_len = w_mode_eff ? c_b_v_sync : c_a_v_sync;
            V_BP:     w_v_len = w_mode_eff ? c_b_v_bp   : c_a_v_bp;
            default:  w_v_len = c_a_v_act;
        endcase
    end

    assign w_h_last    = (r_hcnt == (w_h_len - 11'd1));
    assign w_v_last    = (r_vcnt == (w_v_len - 10'd1));
    assign w_line_end  = (r_h_state == H_BP) && w_h_last;
    assign w_frame_end = w_line_end && (r_v_state == V_BP) && w_v_last;

    // Next-state logic for both timing FSMs
    always_comb begin
        w_h_state_nxt = r_h_state;
        w_hcnt_nxt    = r_hcnt + 11'd1;
        w_v_state_nxt = r_v_state;
        w_vcnt_nxt    = r_vcnt;

        if (w_h_last) begin
            w_hcnt_nxt = '0;
            unique case (r_h_state)
                H_ACTIVE: w_h_state_nxt = H_FP;
                H_FP:     w_h_state_nxt = H_SYNC;
                H_SYNC:   w_h_state_nxt = H_BP;
                H_BP:     w_h_state_nxt = H_ACTIVE;
                default:  w_h_state_nxt = H_ACTIVE;
            endcase
        end

        if (w_line_end) begin
            if (w_v_last) begin
                w_vcnt_nxt = '0;
                unique case (r_v_state)
                    V_ACTIVE: w_v_state_nxt = V_FP;
                    V_FP:     w_v_state_nxt = V_SYNC;
                    V_SYNC:   w_v_state_nxt = V_BP;
                    V_BP:     w_v_state_nxt = V_ACTIVE;
                    default:  w_v_state_nxt = V_ACTIVE;
                endcase
            end else begin
                w_vcnt_nxt = r_vcnt + 10'd1;
            end
        end

        if (!bus.EN) begin
            w_h_state_nxt = H_ACTIVE;
            w_hcnt_nxt    = '0;
            w_v_state_nxt = V_ACTIVE;
            w_vcnt_nxt    = '0;
        end
    end

    always_ff @(posedge VID_CLK) begin
        if (VID_RST) begin
            r_h_state <= H_ACTIVE;
            r_v_state <= V_ACTIVE;
            r_hcnt    <= '0;
            r_vcnt    <= '0;
        end else begin
            r_h_state <= w_h_state_nxt;
            r_v_state <= w_v_state_nxt;
            r_hcnt    <= w_hcnt_nxt;
            r_vcnt    <= w_vcnt_nxt;
        end
    end

    // Timing set is only switched at a frame boundary or on a fresh start
    always_ff @(posedge VID_CLK) begin
        if (VID_RST) begin
            r_en_d     <= 1'b0;
            r_mode_act <= 1'b0;
        end else begin
            r_en_d <= bus.EN;
            if (bus.EN && (w_en_rise || w_frame_end)) begin
                r_mode_act <= bus.MODE;
            end
        end
    end

    assign w_de0 = (r_h_state == H_ACTIVE) && (r_v_state == V_ACTIVE);
    assign w_hs0 = (r_h_state == H_SYNC);
    assign w_vs0 = (r_v_state == V_SYNC);
    assign w_fs0 = w_de0 && (r_hcnt == 11'd0) && (r_vcnt == 10'd0);

    // Stage 1: fetch request; coordinates hold outside the active area
    always_ff @(posedge VID_CLK) begin
        if (VID_RST || !bus.EN) begin
            r_pix_req <= 1'b0;
            r_pix_x   <= '0;
            r_pix_y   <= '0;
            r_hs1     <= 1'b0;
            r_vs1     <= 1'b0;
            r_fs1     <= 1'b0;
        end else begin
            r_pix_req <= w_de0;
            r_hs1     <= w_hs0;
            r_vs1     <= w_vs0;
            r_fs1     <= w_fs0;
            if (w_de0) begin
                r_pix_x <= r_hcnt;
                r_pix_y <= r_vcnt;
            end
        end
    end

    // Stage 2: pixel returned for the stage-1 request is latched with its syncs
    always_ff @(posedge VID_CLK) begin
        if (VID_RST || !bus.EN) begin
            r_vid_de      <= 1'b0;
            r_vid_hs      <= 1'b0;
            r_vid_vs      <= 1'b0;
            r_frame_start <= 1'b0;
            r_vid_r       <= '0;
            r_vid_g       <= '0;
            r_vid_b       <= '0;
        end else begin
            r_vid_de      <= r_pix_req;
            r_vid_hs      <= r_hs1;
            r_vid_vs      <= r_vs1;
            r_frame_start <= r_fs1;
            r_vid_r       <= r_pix_req ? bus.PIX_RGB[14:10] : 5'd0;
            r_vid_g       <= r_pix_req ? bus.PIX_RGB[9:5]   : 5'd0;
            r_vid_b       <= r_pix_req ? bus.PIX_RGB[4:0]   : 5'd0;
        end
    end

    assign bus.PIX_REQ     = r_pix_req;
    assign bus.PIX_X       = r_pix_x;
    assign bus.PIX_Y       = r_pix_y;
    assign bus.VID_R       = r_vid_r;
    assign bus.VID_G       = r_vid_g;
    assign bus.VID_B       = r_vid_b;
    assign bus.VID_HS      = r_vid_hs;
    assign bus.VID_VS      = r_vid_vs;
    assign bus.VID_DE      = r_vid_de;
    assign bus.FRAME_START = r_frame_start;
    assign bus.MODE_ACT    = r_mode_act;

endmodule
`default_nettype wire
